maze_cursor_mover: RTL and testbench

- Upstream stage of the maze checkpoint/square renderer. It owns the player cell index `count` that the renderer consumes.
- Samples the direction buttons on each 10 Hz move tick and steps the cursor one cell on the 18x11 maze grid.
- Moving into a wall cell emits the wall code 255 for a fixed hold period, then respawns the cursor at the renderer's current checkpoint (`begin_spot`).

---
 rtl/maze_pkg.sv | 38 +++
 rtl/maze_cell_to_rc.sv | 16 +
 rtl/maze_cursor_mover.sv | 174 +++++++++++++++++
 tb/tb_maze_cursor_mover.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared constants, state encoding and index helper for the maze cursor
// mover and the checkpoint/square renderer.
package maze_pkg;

    localparam int unsigned COLS       = 18;
    localparam int unsigned ROWS       = 11;
    localparam int unsigned NUM_CELLS  = 198;
    localparam int unsigned START_CELL = 181;
    localparam int unsigned HIT_TICKS  = 10;
    localparam int unsigned WALL_CODE  = 255;

    localparam logic [7:0] START_IDX = 8'd181;
    localparam logic [3:0] START_ROW = 4'd10;
    localparam logic [4:0] START_COL = 5'd1;
    localparam logic [7:0] WALL_IDX  = 8'd255;
    localparam logic [7:0] LAST_IDX  = 8'd197;
    localparam logic [3:0] LAST_ROW  = 4'd10;
    localparam logic [4:0] LAST_COL  = 5'd17;
    localparam logic [3:0] HIT_LAST  = 4'd9;

    // Checkpoint cells the renderer may hand back as begin_spot.
    localparam logic [7:0] CHECKPOINT_0 = 8'd31;
    localparam logic [7:0] CHECKPOINT_1 = 8'd113;
    localparam logic [7:0] CHECKPOINT_2 = 8'd178;
    localparam logic [7:0] CHECKPOINT_3 = 8'd37;
    localparam logic [7:0] CHECKPOINT_4 = 8'd139;

    typedef enum logic [1:0] {
        ST_ALIVE   = 2'd0,
        ST_HIT     = 2'd1,
        ST_RESPAWN = 2'd2
    } cursor_state_e;

    function automatic logic [7:0] rc_to_idx(input logic [3:0] row, input logic [4:0] col);
        return ({4'd0, row} * 8'd18) + {3'd0, col};
    endfunction

endpackage

// File: rtl/maze_cell_to_rc.sv
// Combinational split of a linear cell index into grid row and column.
module maze_cell_to_rc
    import maze_pkg::*;
(
    input  logic [7:0] idx,
    output logic [3:0] row,
    output logic [4:0] col
);

    // Constant divide/modulo by the column count; callers only pass indices <= 197.
    always_comb begin
        row = 4'(idx / 8'(COLS));
        col = 5'(idx % 8'(COLS));
    end

endmodule

// File: rtl/maze_cursor_mover.sv
// Steps the player cursor across the maze grid on each move tick, holds the
// wall code after a wall hit, then respawns at the renderer's checkpoint.
module maze_cursor_mover
    import maze_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET,
    input  logic         move_tick,
    input  logic         btnU,
    input  logic         btnD,
    input  logic         btnL,
    input  logic         btnR,
    input  logic         freeze,
    input  logic [197:0] mazestate,
    input  logic [7:0]   begin_spot,
    output logic [7:0]   count,
    output logic         hit_pulse,
    output logic         moved
);

    cursor_state_e state_q, state_d;
    logic [3:0]    row_q, row_d;
    logic [4:0]    col_q, col_d;
    logic [3:0]    hit_cnt_q, hit_cnt_d;
    logic [7:0]    count_q, count_d;
    logic          hit_pulse_q, hit_pulse_d;
    logic          moved_q, moved_d;

    logic          step_req_s;
    logic          at_edge_s;
    logic [3:0]    tgt_row_s;
    logic [4:0]    tgt_col_s;
    logic [7:0]    tgt_idx_s;
    logic          tgt_open_s;
    logic          tick_go_s;

    logic [7:0]    rs_idx_s;
    logic [3:0]    rs_row_s;
    logic [4:0]    rs_col_s;

    // Out-of-range checkpoints fall back to the trusted start cell.
    assign rs_idx_s = (begin_spot <= LAST_IDX) ? begin_spot : START_IDX;

    maze_cell_to_rc u_respawn_rc (
        .idx (rs_idx_s),
        .row (rs_row_s),
        .col (rs_col_s)
    );

    // Pick the highest-priority direction and work out the neighbouring cell.
    always_comb begin
        tgt_row_s  = row_q;
        tgt_col_s  = col_q;
        at_edge_s  = 1'b0;
        step_req_s = 1'b1;
        if (btnU) begin
            at_edge_s = (row_q == 4'd0);
            tgt_row_s = row_q - 4'd1;
        end else if (btnD) begin
            at_edge_s = (row_q == LAST_ROW);
            tgt_row_s = row_q + 4'd1;
        end else if (btnL) begin
            at_edge_s = (col_q == 5'd0);
            tgt_col_s = col_q - 5'd1;
        end else if (btnR) begin
            at_edge_s = (col_q == LAST_COL);
            tgt_col_s = col_q + 5'd1;
        end else begin
            step_req_s = 1'b0;
        end
        tgt_idx_s  = rc_to_idx(tgt_row_s, tgt_col_s);
        if (tgt_idx_s <= LAST_IDX) begin
            tgt_open_s = mazestate[tgt_idx_s];
        end else begin
            tgt_open_s = 1'b0;
        end
        tick_go_s = move_tick & ~freeze & step_req_s & ~at_edge_s;
    end

    // State register plus position, hit counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= ST_ALIVE;
            row_q       <= START_ROW;
            col_q       <= START_COL;
            hit_cnt_q   <= 4'd0;
            count_q     <= START_IDX;
            hit_pulse_q <= 1'b0;
            moved_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            hit_cnt_q   <= hit_cnt_d;
            count_q     <= count_d;
            hit_pulse_q <= hit_pulse_d;
            moved_q     <= moved_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ALIVE: begin
                if (tick_go_s && !tgt_open_s) begin
                    state_d = ST_HIT;
                end else begin
                    state_d = ST_ALIVE;
                end
            end
            ST_HIT: begin
                if (move_tick && (hit_cnt_q == HIT_LAST)) begin
                    state_d = ST_RESPAWN;
                end else begin
                    state_d = ST_HIT;
                end
            end
            ST_RESPAWN: state_d = ST_ALIVE;
            default:    state_d = ST_ALIVE;
        endcase
    end

    // Datapath and output values for the next edge.
    always_comb begin
        row_d       = row_q;
        col_d       = col_q;
        hit_cnt_d   = hit_cnt_q;
        count_d     = count_q;
        hit_pulse_d = 1'b0;
        moved_d     = 1'b0;
        case (state_q)
            ST_ALIVE: begin
                if (tick_go_s && tgt_open_s) begin
                    row_d   = tgt_row_s;
                    col_d   = tgt_col_s;
                    count_d = tgt_idx_s;
                    moved_d = 1'b1;
                end else if (tick_go_s) begin
                    count_d     = WALL_IDX;
                    hit_pulse_d = 1'b1;
                    hit_cnt_d   = 4'd0;
                end else begin
                    count_d = count_q;
                end
            end
            ST_HIT: begin
                count_d = WALL_IDX;
                if (move_tick) begin
                    hit_cnt_d = (hit_cnt_q == HIT_LAST) ? 4'd0 : hit_cnt_q + 4'd1;
                end else begin
                    hit_cnt_d = hit_cnt_q;
                end
            end
            ST_RESPAWN: begin
                row_d     = rs_row_s;
                col_d     = rs_col_s;
                count_d   = rs_idx_s;
                hit_cnt_d = 4'd0;
            end
            default: begin
                row_d     = START_ROW;
                col_d     = START_COL;
                count_d   = START_IDX;
                hit_cnt_d = 4'd0;
            end
        endcase
    end

    assign count     = count_q;
    assign hit_pulse = hit_pulse_q;
    assign moved     = moved_q;

endmodule

// File: tb/tb_maze_cursor_mover.sv
// Directed bench for maze_cursor_mover with hand-computed cell indices.
module tb_maze_cursor_mover;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         move_tick;
    logic         btnU, btnD, btnL, btnR;
    logic         freeze;
    logic [197:0] mazestate;
    logic [7:0]   begin_spot;
    logic [7:0]   count;
    logic         hit_pulse;
    logic         moved;

    int checks = 0;
    int errors = 0;

    maze_cursor_mover dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .move_tick  (move_tick),
        .btnU       (btnU),
        .btnD       (btnD),
        .btnL       (btnL),
        .btnR       (btnR),
        .freeze     (freeze),
        .mazestate  (mazestate),
        .begin_spot (begin_spot),
        .count      (count),
        .hit_pulse  (hit_pulse),
        .moved      (moved)
    );

    always #80 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic tick();
        move_tick = 1'b1;
        @(posedge CLK);
        #1;
        move_tick = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    task automatic set_btns(input logic u, input logic d, input logic l, input logic r);
        btnU = u;
        btnD = d;
        btnL = l;
        btnR = r;
    endtask

    initial begin
        int exp_cell;
        RESET      = 1'b0;
        move_tick  = 1'b0;
        freeze     = 1'b0;
        set_btns(1'b0, 1'b0, 1'b0, 1'b0);
        mazestate  = '1;
        begin_spot = 8'd113;
        idle(2);
        RESET = 1'b1;

        // Reset state
        check_eq("rst_count", count, 32'd181);
        check_eq("rst_hit_pulse", hit_pulse, 32'd0);
        check_eq("rst_moved", moved, 32'd0);

        // Bottom edge: D at row 10 does nothing
        set_btns(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("edge_d_count", count, 32'd181);
        check_eq("edge_d_moved", moved, 32'd0);

        // Held U auto-repeats 181 -> 163 -> 145 -> 127
        set_btns(1'b1, 1'b0, 1'b0, 1'b0);
        exp_cell = 181;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_cell -= 18;
            check_eq("up_count", count, exp_cell);
            check_eq("up_moved", moved, 32'd1);
        end
        idle(1);
        check_eq("moved_one_cycle", moved, 32'd0);

        // Continue to row 0 (cell 1), then L to cell 0
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        check_eq("row0_count", count, 32'd1);
        tick();
        check_eq("edge_u_row0", count, 32'd1);
        check_eq("edge_u_row0_moved", moved, 32'd0);
        set_btns(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_eq("left_to_0", count, 32'd0);
        tick();
        check_eq("edge_l_count", count, 32'd0);
        check_eq("edge_l_moved", moved, 32'd0);
        set_btns(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("edge_u_count", count, 32'd0);
        check_eq("edge_u_moved", moved, 32'd0);

        // Wall hit, hold (freeze ignored), respawn at 113, RESPAWN-cycle tick ignored
        do_reset();
        mazestate[163] = 1'b0;
        begin_spot     = 8'd113;
        tick();
        check_eq("hit_count", count, 32'd255);
        check_eq("hit_pulse", hit_pulse, 32'd1);
        idle(1);
        check_eq("hit_pulse_one_cycle", hit_pulse, 32'd0);
        freeze = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        freeze = 1'b0;
        check_eq("hit_hold_9", count, 32'd255);
        tick();
        check_eq("hit_hold_10", count, 32'd255);
        tick();
        check_eq("respawn_113", count, 32'd113);
        tick();
        check_eq("after_respawn_up", count, 32'd95);

        // U beats R; freeze holds position
        do_reset();
        mazestate = '1;
        set_btns(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("prio_u_over_r", count, 32'd163);
        freeze = 1'b1;
        tick();
        check_eq("freeze_count", count, 32'd163);
        check_eq("freeze_moved", moved, 32'd0);
        freeze = 1'b0;

        // Invalid begin_spot falls back to START_CELL
        do_reset();
        mazestate[163] = 1'b0;
        set_btns(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        begin_spot = 8'd200;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        idle(1);
        check_eq("respawn_fallback", count, 32'd181);

        // Reset mid-HIT, then R step and a fresh full hold period
        do_reset();
        begin_spot = 8'd113;
        tick();
        check_eq("hit2_count", count, 32'd255);
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        do_reset();
        check_eq("rst_mid_hit", count, 32'd181);
        set_btns(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("right_after_rst", count, 32'd182);
        mazestate[164] = 1'b0;
        set_btns(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("hit3_count", count, 32'd255);
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        idle(1);
        check_eq("hit_cnt_cleared", count, 32'd255);
        tick();
        idle(1);
        check_eq("respawn_after_rst", count, 32'd113);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
